// File: rtl/cursor_move_ctrl.sv
// cursor_move_ctrl
// Turns debounced button levels into single events, steers the 8x8 board
// cursor and runs the select-source / select-destination / request sequence
// toward the game logic over a valid/ready handshake.
//
// Build option: define CURSOR_WRAP_EN to make the cursor wrap modulo 8.
// Without it the cursor saturates at 0 and 7.
//
// state | meaning
// ------+------------------------------------------------------------
// SRC   | choosing a source square; C latches it if own_piece is set
// DST   | source latched; choosing a destination; C on source cancels
// REQ   | move request pending; buttons ignored, cursor frozen
module cursor_move_ctrl #(
    parameter int START_X     = 4,
    parameter int START_Y     = 0,
    parameter int REQ_TIMEOUT = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BtnU_pulse,
    input  logic       BtnD_pulse,
    input  logic       BtnL_pulse,
    input  logic       BtnR_pulse,
    input  logic       BtnC_pulse,
    input  logic       own_piece,
    input  logic       move_ready,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       sel_active,
    output logic [2:0] sel_x,
    output logic [2:0] sel_y,
    output logic       move_valid,
    output logic [5:0] move_src,
    output logic [5:0] move_dst,
    output logic       sel_err
);

    typedef enum logic [1:0] {S_SRC, S_DST, S_REQ} state_t;

    // Counter only needs to reach REQ_TIMEOUT-1; the terminal value ends REQ.
    localparam int CW      = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
    localparam int TO_LAST = (REQ_TIMEOUT > 0) ? REQ_TIMEOUT - 1 : 0;

    state_t          state, state_nxt;
    logic [4:0]      btn, btn_prev, btn_ev;
    logic            ev_c, ev_u, ev_d, ev_l, ev_r;
    logic            at_sel, timeout_hit;
    logic [CW-1:0]   req_cnt;
    logic            latch_sel, latch_move, err_nxt;
    logic [2:0]      x_nxt, y_nxt;

    function automatic logic [2:0] step_up(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
        return v + 3'd1;
`else
        return (v == 3'd7) ? v : v + 3'd1;
`endif
    endfunction

    function automatic logic [2:0] step_down(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
        return v - 3'd1;
`else
        return (v == 3'd0) ? v : v - 3'd1;
`endif
    endfunction

    // Rising-edge events with fixed priority C > U > D > L > R; losers are dropped.
    always_comb begin
        btn    = {BtnC_pulse, BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse};
        btn_ev = btn & ~btn_prev;
        ev_c   = btn_ev[4];
        ev_u   = ~btn_ev[4] & btn_ev[3];
        ev_d   = ~|btn_ev[4:3] & btn_ev[2];
        ev_l   = ~|btn_ev[4:2] & btn_ev[1];
        ev_r   = ~|btn_ev[4:1] & btn_ev[0];
    end

    assign at_sel      = (cursor_x == sel_x) && (cursor_y == sel_y);
    assign timeout_hit = (REQ_TIMEOUT > 0) && (req_cnt == CW'(TO_LAST));

    // State register; async reset drops any pending request at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_SRC;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_SRC: if (ev_c && own_piece) state_nxt = S_DST;
            S_DST: if (ev_c)              state_nxt = at_sel ? S_SRC : S_REQ;
            S_REQ: if (move_ready || timeout_hit) state_nxt = S_SRC;
            default:                      state_nxt = S_SRC;
        endcase
    end

    // Moore status outputs plus datapath enables and next cursor position.
    always_comb begin
        move_valid = (state == S_REQ);
        sel_active = (state != S_SRC);
        latch_sel  = (state == S_SRC) && ev_c && own_piece;
        latch_move = (state == S_DST) && ev_c && !at_sel;
        // A handshake on the timeout edge wins, so no error in that case.
        err_nxt    = ((state == S_SRC) && ev_c && !own_piece) ||
                     ((state == S_REQ) && !move_ready && timeout_hit);
        x_nxt      = cursor_x;
        y_nxt      = cursor_y;
        if (state != S_REQ) begin
            if (ev_u) y_nxt = step_up(cursor_y);
            if (ev_d) y_nxt = step_down(cursor_y);
            if (ev_r) x_nxt = step_up(cursor_x);
            if (ev_l) x_nxt = step_down(cursor_x);
        end
    end

    // Cursor, selection, request payload, error pulse, edge history and timer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cursor_x <= 3'(START_X);
            cursor_y <= 3'(START_Y);
            sel_x    <= 3'd0;
            sel_y    <= 3'd0;
            move_src <= 6'd0;
            move_dst <= 6'd0;
            sel_err  <= 1'b0;
            btn_prev <= 5'd0;
            req_cnt  <= '0;
        end else begin
            cursor_x <= x_nxt;
            cursor_y <= y_nxt;
            btn_prev <= btn;
            sel_err  <= err_nxt;
            if (latch_sel) begin
                sel_x <= cursor_x;
                sel_y <= cursor_y;
            end
            if (latch_move) begin
                move_src <= {sel_y, sel_x};
                move_dst <= {cursor_y, cursor_x};
            end
            if (state == S_REQ) req_cnt <= req_cnt + 1'b1;
            else                req_cnt <= '0;
        end
    end

endmodule
